// File: rtl/dcls_err_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : dcls_err_manager_if
// Description : Control/status bundle between a DCLS comparator host and
//               the dcls_err_manager. The master drives enable, requests
//               and comparator flags; the slave returns comparator controls
//               and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcls_err_manager_if;
    logic EN;
    logic BIST_REQ;
    logic FAULT_CLR;
    logic ERR_DCLS;
    logic ERR_DCLS_B;
    logic ENERR_DCLS;
    logic FIERR_DCLS;
    logic BIST_BUSY;
    logic BIST_DONE;
    logic BIST_PASS;
    logic FAULT;
    logic PAIR_ERR;

    modport master (
        output EN, BIST_REQ, FAULT_CLR, ERR_DCLS, ERR_DCLS_B,
        input  ENERR_DCLS, FIERR_DCLS, BIST_BUSY, BIST_DONE, BIST_PASS,
               FAULT, PAIR_ERR
    );

    modport slave (
        input  EN, BIST_REQ, FAULT_CLR, ERR_DCLS, ERR_DCLS_B,
        output ENERR_DCLS, FIERR_DCLS, BIST_BUSY, BIST_DONE, BIST_PASS,
               FAULT, PAIR_ERR
    );
endinterface
`default_nettype wire

// File: rtl/dcls_err_manager.sv
`default_nettype none
// ============================================================================
// Module      : dcls_err_manager
// Description : Error manager for a dual-core lockstep comparator. Sequences
//               comparator enable, pipeline flush, fault monitoring and
//               fault-injection self-test; keeps sticky FAULT / PAIR_ERR.
//               Optional macro DCLS_ERR_MANAGER_PERIODIC_BIST_EN adds a
//               periodic auto self-test timer (BIST_PERIOD cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module dcls_err_manager #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_LAT    = 1,
    parameter int BIST_PERIOD = 65536
) (
    input  logic               CLK,
    input  logic               RESET,
    dcls_err_manager_if.slave  bus
);
    localparam int c_CLR_CYCLES  = PIPE_LAT + 2;
    localparam int c_BIST_CYCLES = 2 * DATA_WIDTH + PIPE_LAT + 2;
    localparam int c_CNT_MAX     = (c_BIST_CYCLES > c_CLR_CYCLES) ? c_BIST_CYCLES : c_CLR_CYCLES;
    localparam int c_CNT_W       = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CLR_LOAD  = c_CNT_W'(c_CLR_CYCLES);
    localparam logic [c_CNT_W-1:0] c_BIST_LOAD = c_CNT_W'(c_BIST_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Reject configurations that would make the counters meaningless.
    if (PIPE_LAT < 1 || DATA_WIDTH < 1 || BIST_PERIOD < 1) begin : g_param_check
        $error("dcls_err_manager: PIPE_LAT, DATA_WIDTH and BIST_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLEAR    = 2'd1,
        S_MONITOR  = 2'd2,
        S_BIST_RUN = 2'd3
    } t_state;

    t_state              r_state;
    t_state              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    logic                r_pass;
    logic                w_pass_nxt;
    logic                w_done_nxt;
    logic                r_done;
    logic                r_enerr;
    logic                r_fierr;
    logic                r_busy;
    logic                r_pair_prev;
    logic                r_pair_err;
    logic                w_err_sample;
    logic                w_pair_eq;
    logic                w_auto_bist;
    logic                w_bist_start;

    // A genuine mismatch: active-high flag set and its complement cleared.
    assign w_err_sample = bus.ERR_DCLS & ~bus.ERR_DCLS_B;
    assign w_pair_eq    = (bus.ERR_DCLS == bus.ERR_DCLS_B);
    assign w_bist_start = bus.BIST_REQ | w_auto_bist;

`ifdef DCLS_ERR_MANAGER_PERIODIC_BIST_EN
    localparam int c_TMR_W = $clog2(BIST_PERIOD + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(BIST_PERIOD - 1);
    logic [c_TMR_W-1:0] r_timer;

    assign w_auto_bist = (r_state == S_MONITOR) && (r_timer == c_TMR_LAST);

    // Auto self-test timer: counts only while staying in MONITOR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_timer <= '0;
        else if (r_state != S_MONITOR || w_state_nxt != S_MONITOR)
            r_timer <= '0;
        else
            r_timer <= r_timer + 1'b1;
    end
`else
    assign w_auto_bist = 1'b0;
`endif

    // State, counter and sticky result registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Next-state logic; EN low overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fault_nxt = r_fault;
        w_pass_nxt  = r_pass;
        w_done_nxt  = 1'b0;
        if (!bus.EN) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = c_CLR_LOAD;
                end
                S_CLEAR: begin
                    // <= 1 also catches a zero count so the counter never wraps.
                    if (r_cnt <= c_CNT_ONE) begin
                        w_state_nxt = S_MONITOR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_MONITOR: begin
                    if (w_bist_start) begin
                        w_state_nxt = S_BIST_RUN;
                        w_cnt_nxt   = c_BIST_LOAD;
                        w_fault_nxt = r_fault | w_err_sample;
                    end else if (bus.FAULT_CLR) begin
                        w_state_nxt = S_CLEAR;
                        w_cnt_nxt   = c_CLR_LOAD;
                        w_fault_nxt = 1'b0;
                    end else begin
                        w_fault_nxt = r_fault | w_err_sample;
                    end
                end
                S_BIST_RUN: begin
                    if (r_cnt <= c_CNT_ONE) begin
                        w_state_nxt = S_CLEAR;
                        w_cnt_nxt   = c_CLR_LOAD;
                        w_pass_nxt  = w_err_sample;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Registered output decode taken from the next state so outputs align with it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_enerr <= 1'b0;
            r_fierr <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_enerr <= (w_state_nxt == S_MONITOR) || (w_state_nxt == S_BIST_RUN);
            r_fierr <= (w_state_nxt == S_BIST_RUN);
            r_busy  <= (w_state_nxt == S_BIST_RUN);
            r_done  <= w_done_nxt;
        end
    end

    // Pair-consistency monitor: two consecutive equal samples latch PAIR_ERR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pair_prev <= 1'b0;
            r_pair_err  <= 1'b0;
        end else begin
            r_pair_prev <= w_pair_eq;
            r_pair_err  <= r_pair_err | (r_pair_prev & w_pair_eq);
        end
    end

    assign bus.ENERR_DCLS = r_enerr;
    assign bus.FIERR_DCLS = r_fierr;
    assign bus.BIST_BUSY  = r_busy;
    assign bus.BIST_DONE  = r_done;
    assign bus.BIST_PASS  = r_pass;
    assign bus.FAULT      = r_fault;
    assign bus.PAIR_ERR   = r_pair_err;

endmodule
`default_nettype wire

// File: doc/dcls_err_manager.md
DCLS_ERR_MANAGER -- requirements
Module: dcls_err_manager

Interface
- REQ-001: The block SHALL expose the following parameters (name, default, meaning):
  - DATA_WIDTH, 32: compared data width of the attached DCLS comparator.
  - PIPE_LAT, 1: comparator mismatch latency in cycles (OR stages + 1).
  - BIST_PERIOD, 65536: auto-BIST interval in cycles (used only under REQ-021).
- REQ-002: The block SHALL have the following ports (name, direction, width, meaning):
  - CLK, in, 1: single clock; all logic on its rising edge.
  - RESET, in, 1: asynchronous, active-high reset.
  - EN, in, 1: level; enables DCLS monitoring.
  - BIST_REQ, in, 1: single-cycle request to run comparator self-test.
  - FAULT_CLR, in, 1: single-cycle request to clear FAULT and re-arm the comparator.
  - ERR_DCLS, in, 1: comparator active-high error flag.
  - ERR_DCLS_B, in, 1: comparator active-low error flag.
  - ENERR_DCLS, out, 1: comparator enable.
  - FIERR_DCLS, out, 1: comparator fault-injection test request.
  - BIST_BUSY, out, 1: high while self-test is running.
  - BIST_DONE, out, 1: one-cycle pulse when self-test completes.
  - BIST_PASS, out, 1: result of the last completed self-test.
  - FAULT, out, 1: sticky flag; real core mismatch reported.
  - PAIR_ERR, out, 1: sticky flag; ERR_DCLS/ERR_DCLS_B pair not complementary.

Function
- REQ-003: States SHALL be IDLE, CLEAR, MONITOR and BIST_RUN.
- REQ-004: Output decode per state (ENERR_DCLS/FIERR_DCLS):
  - IDLE: 0/0.
  - CLEAR: 0/0.
  - MONITOR: 1/0.
  - BIST_RUN: 1/1, with BIST_BUSY=1.
- REQ-005: All outputs SHALL be registered.
- REQ-006: IDLE->CLEAR when EN=1; any state->IDLE when EN=0. EN=0 has priority over every other transition.
- REQ-007: CLEAR SHALL last exactly CLR_CYCLES = PIPE_LAT+2 cycles, flushing the comparator pipeline and its sticky flags, then go to MONITOR.
- REQ-008: In MONITOR, a sample of ERR_DCLS=1 with ERR_DCLS_B=0 SHALL set FAULT on the next edge. FAULT stays set until FAULT_CLR or reset.
- REQ-009: In MONITOR, FAULT_CLR=1 SHALL clear FAULT and go to CLEAR. If FAULT_CLR and a new fault sample occur in the same cycle, the clear wins.
- REQ-010: In MONITOR, BIST_REQ=1 SHALL go to BIST_RUN and load the cycle counter with BIST_CYCLES = 2*DATA_WIDTH+PIPE_LAT+2.
  - BIST_REQ wins over FAULT_CLR in the same cycle.
  - A fault sample taken in that same cycle is still recorded.
- REQ-011: BIST_REQ SHALL be ignored in IDLE, CLEAR and BIST_RUN (no queuing).
- REQ-012: BIST_RUN SHALL decrement the counter each cycle. FAULT SHALL NOT be updated in BIST_RUN.
- REQ-013: In the final BIST_RUN cycle (counter=1), BIST_PASS SHALL load (ERR_DCLS & ~ERR_DCLS_B). The state then goes to CLEAR and BIST_DONE pulses high for exactly that first CLEAR cycle.
- REQ-014: If EN=0 aborts BIST_RUN: go to IDLE, no BIST_DONE pulse, BIST_PASS unchanged.
- REQ-015: PAIR_ERR SHALL set when ERR_DCLS==ERR_DCLS_B for 2 consecutive sampled cycles, in any state. It clears only on reset.
- REQ-016: The counter SHALL be wide enough for max(BIST_CYCLES, CLR_CYCLES) and SHALL never wrap.

Reset
- REQ-017: RESET=1 SHALL asynchronously force:
  - state IDLE, counters 0;
  - ENERR_DCLS, FIERR_DCLS, BIST_BUSY, BIST_DONE, BIST_PASS, FAULT, PAIR_ERR all 0.
- REQ-018: Reset deassertion mid-operation SHALL restart from IDLE, with first activity no earlier than the cycle after RESET falls.

Configuration
- REQ-019: Macro DCLS_ERR_MANAGER_PERIODIC_BIST_EN SHALL compile in a periodic auto-BIST timer.
- REQ-020: Without the macro, self-test SHALL run only on BIST_REQ, and no timer logic SHALL exist.
- REQ-021: With the macro, a counter runs only in MONITOR and resets on leaving MONITOR. On reaching BIST_PERIOD it SHALL trigger BIST_RUN exactly as BIST_REQ does, then restart from 0.

Verification (DATA_WIDTH=8, PIPE_LAT=1, so BIST_CYCLES=19, CLR_CYCLES=3)
- REQ-022: Reset, then EN=1 -> ENERR_DCLS=0 for 3 cycles, then ENERR_DCLS=1 (MONITOR); all flags remain 0.
- REQ-023: In MONITOR, ERR_DCLS=1 and ERR_DCLS_B=0 for one cycle -> FAULT=1 the next cycle and held. FAULT_CLR pulse -> FAULT=0, ENERR_DCLS=0 for 3 cycles, then back to 1.
- REQ-024: BIST_REQ pulse with a healthy comparator model (ERR=1/ERR_B=0 at end) -> FIERR_DCLS=1 and BIST_BUSY=1 for 19 cycles, then BIST_DONE one-cycle pulse with BIST_PASS=1. A stuck model (ERR=0/ERR_B=1) -> BIST_PASS=0.
- REQ-025: EN dropped at BIST_RUN cycle 5 -> next cycle IDLE, FIERR_DCLS=0, ENERR_DCLS=0, no BIST_DONE pulse, BIST_PASS unchanged.
- REQ-026: ERR_DCLS=ERR_DCLS_B=1 for 1 cycle -> PAIR_ERR stays 0. For 2 cycles -> PAIR_ERR=1, still held after EN toggles.
- REQ-027: With the macro and BIST_PERIOD=50: idle in MONITOR -> BIST_RUN entered at cycle 50, then every 50+19+3 cycles. Without the macro -> no self-test without BIST_REQ.
